hardware_result_uart_tx: RTL
============================

# hardware_result_uart_tx

Serial output sink for the 33-bit optional-result stream produced by the evaluator top entity. Bit 32 of the input word is the valid flag and bits 31:0 are the result. Each valid result is buffered in a small FIFO and sent off-chip over an 8N1 UART line as four bytes, least-significant byte first. Invalid cycles are ignored, and results that arrive while the FIFO is full are dropped and counted.

## Interface

- `CLKS_PER_BIT`, default 16: clock cycles per UART bit. Must be ≥ 2.
- `FIFO_DEPTH`, default 4: number of 32-bit result entries. Must be a power of two, ≥ 2.

- `system1000` in 1: clock. Everything is on the rising edge.
- `system1000_rstn` in 1: reset, asynchronous and active-low.
- `word_i` in 33: result stream. Bit 32 is valid; bits 31:0 are data, sampled only when bit 32 = 1.
- `tx_o` out 1: UART line. Idles high.
- `busy_o` out 1: high when the FSM is not IDLE or the FIFO is non-empty.
- `overflow_o` out 1: sticky. Set on the first dropped result; cleared only by reset.
- `drop_count_o` out 8: number of dropped results, saturating at 255.

## Operation

Reset values (while `system1000_rstn` = 0):
- `tx_o` = 1, `busy_o` = 0, `overflow_o` = 0, `drop_count_o` = 0.
- FIFO empty, FSM in IDLE.

Push rule:
- A valid word (`word_i[32]` = 1) is written into the FIFO when the FIFO is not full, or when a pop happens in the same cycle.
- Otherwise the word is dropped: `overflow_o` is set and `drop_count_o` is incremented, holding at 255.
- Words with bit 32 = 0 have no effect.

FSM states: IDLE, START, DATA, STOP.
- IDLE with FIFO non-empty:
  - pop the head entry into a 32-bit shift register;
  - set byte index = 0;
  - go to START.
- START: drive `tx_o` = 0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA: send bits 0..7 of the current byte (shift-register bits 7:0), LSB first, `CLKS_PER_BIT` cycles each, then go to STOP.
- STOP: drive `tx_o` = 1 for `CLKS_PER_BIT` cycles, then:
  - if byte index < 3: increment it, shift the register right by 8, go to START;
  - if byte index = 3 and FIFO non-empty: pop the next entry and go straight to START (no idle gap);
  - otherwise go to IDLE.

Other rules:
- Byte order on the wire: data[7:0], [15:8], [23:16], [31:24].
- Bit timer: a counter from 0 to `CLKS_PER_BIT`−1. It wraps at each bit boundary and is reset whenever a state is entered.
- FIFO pointers are log2(`FIFO_DEPTH`)+1 bits wide. Full and empty are decided from the MSB and the remaining bits.
- Reset during a frame takes effect immediately:
  - `tx_o` returns high asynchronously;
  - the partial frame is abandoned and not resumed;
  - FIFO contents are discarded.

## Timing

- Latency: a valid word sampled at edge E while the block is idle and empty is popped at edge E+1, and `tx_o` falls after edge E+1.
- The start bit is therefore visible on the line starting at the cycle after E+1.
- Each bit lasts exactly `CLKS_PER_BIT` cycles. One byte takes 10·`CLKS_PER_BIT` cycles; one word takes 40·`CLKS_PER_BIT` cycles.
- Back-to-back queued words: the next start bit begins on the cycle immediately after the last stop bit of the previous word.
- Sustained throughput is one result per 40·`CLKS_PER_BIT` cycles. A denser valid stream overflows once the FIFO fills.
- Outputs are registered. `tx_o` never glitches within a bit period.

## Test plan

1. With `CLKS_PER_BIT` = 4, drive a single `word_i` = 0x1_DEADBEEF for one cycle. Required response:
   - `tx_o` falls one cycle after the pop edge;
   - decoded bytes are EF, BE, AD, DE;
   - frame length is 160 cycles;
   - `busy_o` drops the cycle after the final stop bit.
2. Drive `word_i` = 0x0_FFFFFFFF continuously for 200 cycles. Required response: `tx_o` stays 1, `busy_o` stays 0, and `drop_count_o` stays 0.
3. With `FIFO_DEPTH` = 4 and the block idle, drive six valid words 1..6 on consecutive cycles. Required response:
   - word 1 is popped immediately;
   - words 2..5 are queued and word 6 is dropped;
   - `overflow_o` = 1 and `drop_count_o` = 1;
   - the line carries words 1..5 back-to-back with no idle bits between them, total 800 cycles.
4. With the FIFO full, present a valid word on the exact cycle a pop occurs. Required response: the word is accepted, `drop_count_o` is unchanged, and the word is transmitted in order.
5. Assert reset during the DATA state of byte 2. Required response: `tx_o` = 1 immediately, all outputs are at their reset values, and after release the line stays idle until a new valid word arrives.
6. Force 300 drops with the FIFO held full. Required response: `drop_count_o` saturates at 255, `overflow_o` = 1, and the queued words are still transmitted intact.

Source files
------------

// File: rtl/hardware_result_uart_tx.sv
// hardware_result_uart_tx
// Serial sink for the evaluator's 33-bit optional-result stream. Valid results
// (bit 32 set) are queued in a small FIFO and shipped as four 8N1 UART bytes,
// least-significant byte first. Results arriving while the FIFO is full (and
// no pop is happening that cycle) are dropped and counted.
module hardware_result_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        system1000,
    input  logic        system1000_rstn,
    input  logic [32:0] word_i,
    output logic        tx_o,
    output logic        busy_o,
    output logic        overflow_o,
    output logic [7:0]  drop_count_o
);

    // FIFO address width; pointers carry one extra wrap bit.
    localparam int AW = $clog2(FIFO_DEPTH);
    // Bit-timer width; CLKS_PER_BIT >= 2 keeps this at least one bit.
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;

    logic          w_empty;
    logic          w_full;
    logic          w_valid_in;
    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    logic [31:0]   w_head;
    logic [AW:0]   w_wr_ptr_next;
    logic [AW:0]   w_rd_ptr_next;
    logic          w_empty_next;

    // ------------------------------------------------------------------
    // Transmitter state
    // ------------------------------------------------------------------
    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [2:0]    r_bit_idx;
    logic [2:0]    w_bit_idx_next;
    logic [1:0]    r_byte_idx;
    logic [1:0]    w_byte_idx_next;
    logic [31:0]   r_shift;
    logic [31:0]   w_shift_next;
    logic          w_bit_end;

    // Registered outputs and drop bookkeeping
    logic          r_tx;
    logic          w_tx_next;
    logic          r_busy;
    logic          w_busy_next;
    logic          r_overflow;
    logic [7:0]    r_drop_count;

    // Full/empty come from comparing the wrap bit and the address bits.
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_head     = r_mem[r_rd_ptr[AW-1:0]];

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_valid_in = word_i[32];
    assign w_push     = w_valid_in && (!w_full || w_pop);
    assign w_drop     = w_valid_in && !w_push;

    assign w_wr_ptr_next = r_wr_ptr + {{AW{1'b0}}, w_push};
    assign w_rd_ptr_next = r_rd_ptr + {{AW{1'b0}}, w_pop};
    assign w_empty_next  = (w_wr_ptr_next == w_rd_ptr_next);

    assign w_bit_end  = (r_cnt == CNT_LAST);

    // Write accepted results into storage (contents need no reset).
    always_ff @(posedge system1000) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= word_i[31:0];
        end
    end

    // Advance FIFO pointers; reset empties the queue.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
        end
    end

    // Next-state logic: frame sequencing, bit timer, byte/bit indices, pops.
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_bit_idx_next  = r_bit_idx;
        w_byte_idx_next = r_byte_idx;
        w_shift_next    = r_shift;
        w_pop           = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (!w_empty) begin
                    w_pop           = 1'b1;
                    w_shift_next    = w_head;
                    w_byte_idx_next = 2'd0;
                    w_bit_idx_next  = 3'd0;
                    w_state_next    = S_START;
                end
            end

            S_START: begin
                if (w_bit_end) begin
                    w_cnt_next     = '0;
                    w_bit_idx_next = 3'd0;
                    w_state_next   = S_DATA;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_next = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            S_STOP: begin
                if (w_bit_end) begin
                    w_cnt_next     = '0;
                    w_bit_idx_next = 3'd0;
                    if (r_byte_idx != 2'd3) begin
                        // Next byte of the same result.
                        w_byte_idx_next = r_byte_idx + 2'd1;
                        w_shift_next    = {8'h00, r_shift[31:8]};
                        w_state_next    = S_START;
                    end else if (!w_empty) begin
                        // Chain straight into the next queued result.
                        w_pop           = 1'b1;
                        w_shift_next    = w_head;
                        w_byte_idx_next = 2'd0;
                        w_state_next    = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Line level and busy flag are computed from the next state so the
    // registered outputs line up exactly with the state they describe.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            S_START: w_tx_next = 1'b0;
            S_DATA:  w_tx_next = w_shift_next[w_bit_idx_next];
            default: w_tx_next = 1'b1;
        endcase
        w_busy_next = (w_state_next != S_IDLE) || !w_empty_next;
    end

    // Transmitter state registers; reset abandons any frame in flight.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= 3'd0;
            r_byte_idx <= 2'd0;
            r_shift    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_bit_idx  <= w_bit_idx_next;
            r_byte_idx <= w_byte_idx_next;
            r_shift    <= w_shift_next;
        end
    end

    // Registered line and busy outputs; the line returns high on reset.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            r_tx   <= 1'b1;
            r_busy <= 1'b0;
        end else begin
            r_tx   <= w_tx_next;
            r_busy <= w_busy_next;
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            r_overflow   <= 1'b0;
            r_drop_count <= 8'd0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != 8'hFF) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    assign tx_o         = r_tx;
    assign busy_o       = r_busy;
    assign overflow_o   = r_overflow;
    assign drop_count_o = r_drop_count;

endmodule
